mdio_master_param: RTL

MDIO_MASTER_PARAM -- requirements
Module: mdio_master_param

---
 rtl/mdio_master_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mdio_master_param.sv
// MDIO (Clause 22 / Clause 45) management-frame master with a parameterised MDC divider and preamble length.
// One command per frame; rsp_valid pulses (PRE_LEN+33)*CLK_DIV cycles after accept (illegal C22 ops: next cycle).
module mdio_master_param #(
    parameter int CLK_DIV = 80,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

    localparam int              CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   LAST     = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   HALF     = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]   HALF_M1  = CW'(CLK_DIV / 2 - 1);
    localparam logic [5:0]      PRE_LAST = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   sr;
    logic [15:0]   rd_sh;
    logic          rd_op;
    logic          ta_err;

    logic accept, illegal, is_read, slot_end, last_bit, sample;

    assign accept   = cmd_valid && cmd_ready;
    assign illegal  = !cmd_c45 && (cmd_op == 2'b00 || cmd_op == 2'b11);
    assign is_read  = cmd_c45 ? cmd_op[1] : (cmd_op == 2'b10);
    assign slot_end = (state != IDLE) && (cnt == LAST);
    assign last_bit = slot_end && (bit_cnt == 6'd0);
    assign sample   = (state != IDLE) && (cnt == HALF_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !illegal) state_nxt = (PRE_LEN > 0) ? PRE : HDR;
            PRE:  if (last_bit) state_nxt = HDR;
            HDR:  if (last_bit) state_nxt = TA;
            TA:   if (last_bit) state_nxt = DATA;
            DATA: if (last_bit) state_nxt = DONE;
            DONE: if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A read turns the line around at the first TA slot and never drives it again.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        mdc       = (cnt >= HALF);
        mdio_o    = 1'b1;
        mdio_oe   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                mdc       = 1'b0;
            end
            PRE: mdio_oe = 1'b1;
            HDR: begin
                mdio_oe = 1'b1;
                mdio_o  = sr[31];
            end
            TA, DATA: begin
                mdio_oe = !rd_op;
                mdio_o  = rd_op ? 1'b1 : sr[31];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            rd_sh     <= '0;
            rd_op     <= 1'b0;
            ta_err    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (accept) begin
                    if (illegal) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        sr      <= {1'b0, !cmd_c45, cmd_op, cmd_phy, cmd_reg, 2'b10, cmd_wdata};
                        rd_op   <= is_read;
                        ta_err  <= 1'b0;
                        rd_sh   <= '0;
                        bit_cnt <= (PRE_LEN > 0) ? PRE_LAST : 6'd13;
                    end
                end
            end else begin
                cnt <= slot_end ? '0 : cnt + CW'(1);
                // mdio_i is captured on the edge that raises mdc.
                if (sample && rd_op) begin
                    if (state == TA && bit_cnt == 6'd0) ta_err <= mdio_i;
                    if (state == DATA) rd_sh <= {rd_sh[14:0], mdio_i};
                end
                if (slot_end) begin
                    if (state == HDR || state == TA || state == DATA) sr <= {sr[30:0], 1'b0};
                    if (bit_cnt != 6'd0) begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end else begin
                        case (state)
                            PRE:     bit_cnt <= 6'd13;
                            HDR:     bit_cnt <= 6'd1;
                            TA:      bit_cnt <= 6'd15;
                            default: bit_cnt <= 6'd0;
                        endcase
                    end
                end
                if (last_bit && state == DONE) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_op ? rd_sh : 16'h0000;
                    rsp_err   <= rd_op ? ta_err : 1'b0;
                end
            end
        end
    end

endmodule
